seg_display_scheduler: RTL and testbench
========================================

Name: seg_display_scheduler

Overview:
- Shares the six-digit seven-segment display between two requesters: the CPU status path and the interrupt handler.
- Drives the scan multiplexer's Data[23:0] and DisplayEnables[5:0] inputs, plus a scan-advance strobe.
- Interrupt messages pre-empt the CPU view for a fixed, blinking hold period. The CPU view is then restored, including any writes made meanwhile.

Parameters:
- SCAN_DIV, 50000: Clock cycles per ScanTick pulse; must be >= 2.
- HOLD_TICKS, 200: ScanTicks an accepted interrupt message stays on the display; must be >= 1.
- BLINK_TICKS, 100: ScanTicks per blink half-period during interrupt hold; must be >= 1.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- CpuWrite  in  1  one-cycle strobe; captures CpuData/CpuMask.
- CpuData  in  24  six BCD/hex nibbles from the CPU, digit 0 = [3:0].
- CpuMask  in  6  per-digit enables from the CPU.
- IrqReq  in  1  level request; held until IrqAck.
- IrqCode  in  24  interrupt message nibbles; valid while IrqReq = 1.
- IrqAck  out  1  one-cycle pulse; IrqCode was captured.
- ScanTick  out  1  one-cycle pulse every SCAN_DIV clocks; scan-advance enable.
- Data  out  24  nibbles to the display multiplexer (registered).
- DisplayEnables  out  6  digit enables to the display multiplexer (registered).
- Owner  out  1  0 = CPU view shown, 1 = interrupt view shown.
- Busy  out  1  1 while in S_IRQ_HOLD.

Behaviour:
- Reset: synchronous, active-high, takes priority over all other inputs. All outputs go to 0, including Data = 24'h0 and DisplayEnables = 6'b0. Registers cleared: cpu shadow (data and mask), irq latch, tick divider, hold and blink counters. State = S_CPU. Reset mid-hold abandons the message without IrqAck.
- Tick divider: counts 0..SCAN_DIV-1. ScanTick = 1 in the cycle the count equals SCAN_DIV-1, then the count wraps to 0. First ScanTick comes SCAN_DIV cycles after Reset deasserts.
- CPU shadow: on CpuWrite, in any state, the shadow takes CpuData/CpuMask next cycle. Last write wins.
- S_CPU:
  - Data/DisplayEnables follow the shadow with 1-cycle latency from CpuWrite.
  - IrqReq = 1 and eligible -> S_IRQ_ACK. Eligible means: first entry after reset, or at least one ScanTick seen since returning to S_CPU (guaranteed minimum CPU visibility).
- S_IRQ_ACK (exactly 1 cycle):
  - Latch IrqCode.
  - IrqAck = 1.
  - Clear hold counter and blink counter; blink phase = on.
  - -> S_IRQ_HOLD.
- S_IRQ_HOLD:
  - Owner = 1, Busy = 1.
  - Data = irq latch.
  - DisplayEnables = 6'b111111 in the on phase, 6'b000000 in the off phase.
  - Each ScanTick increments hold and blink counts. When the blink count reaches BLINK_TICKS it resets and the phase toggles.
  - When the hold count reaches HOLD_TICKS -> S_CPU on that same tick. Outputs show the shadow the next cycle.
- Simultaneous CpuWrite and IrqReq in S_CPU: both honoured. The shadow updates, but the display goes to the interrupt view; the CPU data appears after hold expiry.
- IrqReq during S_IRQ_HOLD: ignored, no IrqAck. If still high on return, re-accepted after the next ScanTick.
- IrqReq dropping before IrqAck: request withdrawn, no effect.
- Owner is 0 in S_CPU and S_IRQ_ACK; the view switches one cycle after IrqAck.
- Outputs are registered; no combinational path from any input to any output.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit.

Decomposition:
- Package seg_sched_pkg holds:
  - State enum: S_CPU = 2'd0, S_IRQ_ACK = 2'd1, S_IRQ_HOLD = 2'd2.
  - Constants ALL_DIGITS_ON = 6'b111111 and ALL_DIGITS_OFF = 6'b000000.
- Sub-module seg_tick_divider (parameter SCAN_DIV; ports Clock, Reset, ScanTick) is reused by other display/LED blocks.

Test Plan (SCAN_DIV=4, HOLD_TICKS=6, BLINK_TICKS=2):
- Reset, then CpuWrite with CpuData=24'h123456, CpuMask=6'b111111 -> next cycle Data=24'h123456, DisplayEnables=6'b111111, Owner=0. ScanTick pulses every 4 cycles, first at cycle 4 after reset.
- IrqReq=1, IrqCode=24'hE00042 -> IrqAck pulses once. Next cycle Data=24'hE00042, Owner=1, Busy=1. Enables pattern 111111 for 2 ticks, 000000 for 2 ticks, 111111 for 2 ticks, then return to the CPU view after 6 ticks (24 cycles).
- CpuWrite 24'hABCDEF/6'b000111 during hold -> Data stays 24'hE00042 until expiry, then shows 24'hABCDEF with enables 6'b000111.
- CpuWrite and IrqReq in the same cycle in S_CPU -> IrqAck = 1, interrupt view shown, shadow = new CPU value after the hold ends.
- IrqReq held high through the whole hold -> no second IrqAck during hold. Second IrqAck arrives after the first ScanTick following the return, and the CPU view is visible in between.
- Reset asserted mid-hold -> next cycle all outputs 0, state S_CPU, no IrqAck. The tick divider restarts, with the first ScanTick 4 cycles after Reset deasserts.

Source files
------------

// File: rtl/seg_sched_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_sched_pkg;

   typedef enum logic [1:0] {
      S_CPU      = 2'd0,
      S_IRQ_ACK  = 2'd1,
      S_IRQ_HOLD = 2'd2
   } sched_state_t;

   localparam logic [5:0] ALL_DIGITS_ON  = 6'b111111;
   localparam logic [5:0] ALL_DIGITS_OFF = 6'b000000;

   // Width of a counter covering 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg_tick_divider.sv
// Free-running divider producing a one-cycle ScanTick every SCAN_DIV clocks.
// Latency: first ScanTick occupies the SCAN_DIV-th cycle after Reset deasserts.
// Backpressure: none; the tick is a free-running strobe.
module seg_tick_divider
   import seg_sched_pkg::*;
#(
   parameter int SCAN_DIV = 50000
)(
   input  logic Clock,
   input  logic Reset,
   output logic ScanTick
);

   localparam int CW = cnt_width(SCAN_DIV);
   localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);
   // The pulse is registered one count early so it lines up with LAST_CNT;
   // this is why SCAN_DIV must be at least 2.
   localparam logic [CW-1:0] PRE_CNT  = CW'(SCAN_DIV - 2);

   logic [CW-1:0] r_count;
   logic          r_tick;

   // Count 0..SCAN_DIV-1 and raise the tick while the count sits at its last value.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_count <= '0;
         r_tick  <= 1'b0;
      end else begin
         if (r_count == LAST_CNT) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
         r_tick <= (r_count == PRE_CNT);
      end
   end

   assign ScanTick = r_tick;

endmodule

// File: rtl/seg_display_scheduler.sv
// Arbitrates the six-digit display between the CPU shadow and blinking interrupt messages.
// Latency: CpuWrite visible 1 cycle later; IrqAck 1 cycle after an eligible IrqReq, irq view 1 cycle after IrqAck.
// Backpressure: IrqReq is held until IrqAck; CpuWrite is never stalled and lands in the shadow in any state.
module seg_display_scheduler
   import seg_sched_pkg::*;
#(
   parameter int SCAN_DIV    = 50000,
   parameter int HOLD_TICKS  = 200,
   parameter int BLINK_TICKS = 100
)(
   input  logic        Clock,
   input  logic        Reset,
   input  logic        CpuWrite,
   input  logic [23:0] CpuData,
   input  logic [5:0]  CpuMask,
   input  logic        IrqReq,
   input  logic [23:0] IrqCode,
   output logic        IrqAck,
   output logic        ScanTick,
   output logic [23:0] Data,
   output logic [5:0]  DisplayEnables,
   output logic        Owner,
   output logic        Busy
);

   localparam int HW = cnt_width(HOLD_TICKS);
   localparam int BW = cnt_width(BLINK_TICKS);
   // Counters stop one short of the parameter: the tick that would reach it is the terminal one.
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

   sched_state_t  r_state, w_state_nxt;
   logic [23:0]   r_sh_data, w_sh_data;
   logic [5:0]    r_sh_mask, w_sh_mask;
   logic [23:0]   r_irq, w_irq;
   logic [HW-1:0] r_hold, w_hold;
   logic [BW-1:0] r_blink, w_blink;
   logic          r_phase, w_phase;
   logic          r_elig, w_elig;

   logic [23:0]   r_data, w_data;
   logic [5:0]    r_en, w_en;
   logic          r_owner, w_owner;
   logic          r_busy, w_busy;
   logic          r_ack, w_ack;
   logic          w_tick;

   seg_tick_divider #(
      .SCAN_DIV (SCAN_DIV)
   ) u_tick_divider (
      .Clock    (Clock),
      .Reset    (Reset),
      .ScanTick (w_tick)
   );

   // Next-state, shadow/latch/counter updates and the next registered output view.
   always_comb begin
      w_state_nxt = r_state;
      w_sh_data   = CpuWrite ? CpuData : r_sh_data;
      w_sh_mask   = CpuWrite ? CpuMask : r_sh_mask;
      w_irq       = r_irq;
      w_hold      = r_hold;
      w_blink     = r_blink;
      w_phase     = r_phase;
      w_elig      = r_elig;

      case (r_state)
         S_CPU: begin
            // A tick seen while the CPU owns the display guarantees it was visible for a while.
            if (w_tick) begin
               w_elig = 1'b1;
            end
            if (IrqReq && r_elig) begin
               w_state_nxt = S_IRQ_ACK;
            end
         end
         S_IRQ_ACK: begin
            w_irq       = IrqCode;
            w_hold      = '0;
            w_blink     = '0;
            w_phase     = 1'b1;
            w_state_nxt = S_IRQ_HOLD;
         end
         S_IRQ_HOLD: begin
            if (w_tick) begin
               if (r_hold == HOLD_LAST) begin
                  w_state_nxt = S_CPU;
                  w_elig      = 1'b0;
               end else begin
                  w_hold = r_hold + 1'b1;
               end
               if (r_blink == BLINK_LAST) begin
                  w_blink = '0;
                  w_phase = ~r_phase;
               end else begin
                  w_blink = r_blink + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = S_CPU;
         end
      endcase

      // Outputs are registered from the next-cycle view so the display flips with the state.
      w_ack   = (w_state_nxt == S_IRQ_ACK);
      w_data  = w_sh_data;
      w_en    = w_sh_mask;
      w_owner = 1'b0;
      w_busy  = 1'b0;
      if (w_state_nxt == S_IRQ_HOLD) begin
         w_data  = w_irq;
         w_en    = w_phase ? ALL_DIGITS_ON : ALL_DIGITS_OFF;
         w_owner = 1'b1;
         w_busy  = 1'b1;
      end
   end

   // State register plus shadow, latch, counters and output registers.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state   <= S_CPU;
         r_sh_data <= '0;
         r_sh_mask <= '0;
         r_irq     <= '0;
         r_hold    <= '0;
         r_blink   <= '0;
         r_phase   <= 1'b0;
         r_elig    <= 1'b1;
         r_data    <= '0;
         r_en      <= '0;
         r_owner   <= 1'b0;
         r_busy    <= 1'b0;
         r_ack     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_sh_data <= w_sh_data;
         r_sh_mask <= w_sh_mask;
         r_irq     <= w_irq;
         r_hold    <= w_hold;
         r_blink   <= w_blink;
         r_phase   <= w_phase;
         r_elig    <= w_elig;
         r_data    <= w_data;
         r_en      <= w_en;
         r_owner   <= w_owner;
         r_busy    <= w_busy;
         r_ack     <= w_ack;
      end
   end

   assign IrqAck         = r_ack;
   assign ScanTick       = w_tick;
   assign Data           = r_data;
   assign DisplayEnables = r_en;
   assign Owner          = r_owner;
   assign Busy           = r_busy;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler with SCAN_DIV=4, HOLD_TICKS=6, BLINK_TICKS=2.
// Expected display views are queued when stimulus is driven and popped as the view changes.
// Each scenario task owns its comparisons; a single summary line ends the run.
module tb_seg_display_scheduler;

   localparam int SCAN_DIV    = 4;
   localparam int HOLD_TICKS  = 6;
   localparam int BLINK_TICKS = 2;

   logic        Clock    = 1'b0;
   logic        Reset    = 1'b1;
   logic        CpuWrite = 1'b0;
   logic [23:0] CpuData  = '0;
   logic [5:0]  CpuMask  = '0;
   logic        IrqReq   = 1'b0;
   logic [23:0] IrqCode  = '0;
   logic        IrqAck;
   logic        ScanTick;
   logic [23:0] Data;
   logic [5:0]  DisplayEnables;
   logic        Owner;
   logic        Busy;

   always #5 Clock = ~Clock;

   seg_display_scheduler #(
      .SCAN_DIV    (SCAN_DIV),
      .HOLD_TICKS  (HOLD_TICKS),
      .BLINK_TICKS (BLINK_TICKS)
   ) dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .CpuWrite       (CpuWrite),
      .CpuData        (CpuData),
      .CpuMask        (CpuMask),
      .IrqReq         (IrqReq),
      .IrqCode        (IrqCode),
      .IrqAck         (IrqAck),
      .ScanTick       (ScanTick),
      .Data           (Data),
      .DisplayEnables (DisplayEnables),
      .Owner          (Owner),
      .Busy           (Busy)
   );

   typedef struct packed {
      logic [23:0] data;
      logic [5:0]  en;
      logic        owner;
      logic        busy;
   } view_t;

   typedef struct {
      view_t v;
      int    ticks;
   } exp_t;

   exp_t exp_q[$];
   int   tick_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   function automatic view_t cur_view();
      return {Data, DisplayEnables, Owner, Busy};
   endfunction

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic push_exp(input logic [23:0] d, input logic [5:0] e, input logic o,
                           input logic b, input int t);
      exp_t x;
      x.v     = {d, e, o, b};
      x.ticks = t;
      exp_q.push_back(x);
   endtask

   // Wait until a ScanTick is seen while the CPU owns the display, then one more cycle.
   task automatic wait_eligible(input string tag);
      bit seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         step();
         if (ScanTick && !Owner && !Busy) seen = 1;
      end
      step();
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL %s_eligible: no ScanTick in CPU view within 20 cycles", tag);
      end
   endtask

   task automatic test_reset();
      int t;
      Reset = 1'b1;
      repeat (3) step();
      vectors++;
      if ({Data, DisplayEnables, Owner, Busy, IrqAck, ScanTick} !== 33'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: got data=%h en=%b own=%b busy=%b ack=%b tick=%b, want all 0",
                  Data, DisplayEnables, Owner, Busy, IrqAck, ScanTick);
      end
      Reset = 1'b0;
      // Pulse must occupy the 4th cycle after release, i.e. show after the 3rd edge, then every 4.
      tick_q.push_back(3);
      tick_q.push_back(7);
      tick_q.push_back(11);
      for (int n = 1; n <= 12; n++) begin
         step();
         if (ScanTick) begin
            vectors++;
            t = (tick_q.size() > 0) ? tick_q.pop_front() : -1;
            if (n != t) begin
               miscompares++;
               $display("FAIL reset_tick_period: ScanTick at step %0d, want step %0d", n, t);
            end
         end
      end
      vectors++;
      if (tick_q.size() != 0) begin
         miscompares++;
         $display("FAIL reset_tick_count: %0d expected ScanTicks missing, want 0", tick_q.size());
         tick_q.delete();
      end
   endtask

   task automatic test_cpu_write();
      logic [23:0] d_tab [3] = '{24'h111111, 24'h222222, 24'h123456};
      logic [5:0]  m_tab [3] = '{6'b000001, 6'b000010, 6'b111111};
      for (int i = 0; i < 3; i++) begin
         CpuWrite = 1'b1;
         CpuData  = d_tab[i];
         CpuMask  = m_tab[i];
         step();
         vectors++;
         if (Data !== d_tab[i] || DisplayEnables !== m_tab[i] || Owner !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_write_%0d: got data=%h en=%b own=%b, want data=%h en=%b own=0",
                     i, Data, DisplayEnables, Owner, d_tab[i], m_tab[i]);
         end
      end
      CpuWrite = 1'b0;
   endtask

   task automatic test_irq_hold();
      view_t prev, cur;
      exp_t  e;
      int    ticks = 0, acks = 0;
      bit    wrote = 0;
      push_exp(24'hE00042, 6'b111111, 1'b1, 1'b1, 0);
      push_exp(24'hE00042, 6'b000000, 1'b1, 1'b1, 2);
      push_exp(24'hE00042, 6'b111111, 1'b1, 1'b1, 4);
      push_exp(24'hABCDEF, 6'b000111, 1'b0, 1'b0, 6);
      prev    = cur_view();
      IrqReq  = 1'b1;
      IrqCode = 24'hE00042;
      for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
         step();
         CpuWrite = 1'b0;
         cur = cur_view();
         if (IrqAck) begin
            acks++;
            IrqReq = 1'b0;
            vectors++;
            if (Owner !== 1'b0) begin
               miscompares++;
               $display("FAIL irq_ack_owner: Owner=%b during IrqAck, want 0", Owner);
            end
         end
         if (cur !== prev) begin
            e = exp_q.pop_front();
            vectors++;
            if (cur !== e.v || ticks != e.ticks) begin
               miscompares++;
               $display("FAIL irq_hold_view: got data=%h en=%b own=%b busy=%b at tick %0d, want data=%h en=%b own=%b busy=%b at tick %0d",
                        cur.data, cur.en, cur.owner, cur.busy, ticks,
                        e.v.data, e.v.en, e.v.owner, e.v.busy, e.ticks);
            end
            prev = cur;
         end
         if (Busy && ScanTick) ticks++;
         if (Busy && !wrote) begin
            CpuWrite = 1'b1;
            CpuData  = 24'hABCDEF;
            CpuMask  = 6'b000111;
            wrote    = 1;
         end
      end
      IrqReq   = 1'b0;
      CpuWrite = 1'b0;
      vectors++;
      if (exp_q.size() != 0 || acks != 1) begin
         miscompares++;
         $display("FAIL irq_hold_done: %0d views pending, %0d acks, want 0 pending and 1 ack",
                  exp_q.size(), acks);
      end
      exp_q.delete();
   endtask

   task automatic test_simultaneous();
      view_t prev, cur;
      exp_t  e;
      int    ticks = 0, acks = 0;
      wait_eligible("simul");
      push_exp(24'h654321, 6'b111111, 1'b0, 1'b0, 0);
      push_exp(24'h0BAD00, 6'b111111, 1'b1, 1'b1, 0);
      push_exp(24'h0BAD00, 6'b000000, 1'b1, 1'b1, 2);
      push_exp(24'h0BAD00, 6'b111111, 1'b1, 1'b1, 4);
      push_exp(24'h654321, 6'b111111, 1'b0, 1'b0, 6);
      prev     = cur_view();
      CpuWrite = 1'b1;
      CpuData  = 24'h654321;
      CpuMask  = 6'b111111;
      IrqReq   = 1'b1;
      IrqCode  = 24'h0BAD00;
      for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
         step();
         CpuWrite = 1'b0;
         cur = cur_view();
         if (IrqAck) begin
            acks++;
            IrqReq = 1'b0;
         end
         if (cur !== prev) begin
            e = exp_q.pop_front();
            vectors++;
            if (cur !== e.v || ticks != e.ticks) begin
               miscompares++;
               $display("FAIL simul_view: got data=%h en=%b own=%b busy=%b at tick %0d, want data=%h en=%b own=%b busy=%b at tick %0d",
                        cur.data, cur.en, cur.owner, cur.busy, ticks,
                        e.v.data, e.v.en, e.v.owner, e.v.busy, e.ticks);
            end
            prev = cur;
         end
         if (Busy && ScanTick) ticks++;
      end
      IrqReq = 1'b0;
      vectors++;
      if (exp_q.size() != 0 || acks != 1) begin
         miscompares++;
         $display("FAIL simul_done: %0d views pending, %0d acks, want 0 pending and 1 ack",
                  exp_q.size(), acks);
      end
      exp_q.delete();
   endtask

   task automatic test_held_request();
      exp_t e;
      int   acks = 0, acks_in_hold = 0, hold_ticks = 0, post_ticks = 0;
      bit   was_busy = 0, returned = 0, second = 0;
      wait_eligible("held");
      push_exp(24'h654321, 6'b111111, 1'b0, 1'b0, HOLD_TICKS);
      IrqReq  = 1'b1;
      IrqCode = 24'h111111;
      for (int c = 0; c < 120 && !second; c++) begin
         step();
         if (IrqAck) begin
            acks++;
            if (was_busy && !returned) acks_in_hold++;
            if (returned) begin
               second = 1;
               IrqReq = 1'b0;
               vectors++;
               if (post_ticks < 1) begin
                  miscompares++;
                  $display("FAIL held_reaccept: second IrqAck after %0d CPU ticks, want >= 1", post_ticks);
               end
            end
         end
         if (Busy) was_busy = 1;
         if (was_busy && !Busy && !returned) begin
            returned = 1;
            e = exp_q.pop_front();
            vectors++;
            if (cur_view() !== e.v || hold_ticks != e.ticks) begin
               miscompares++;
               $display("FAIL held_return_view: got data=%h en=%b own=%b after %0d ticks, want data=%h en=%b own=0 after %0d ticks",
                        Data, DisplayEnables, Owner, hold_ticks, e.v.data, e.v.en, e.ticks);
            end
         end
         if (Busy && ScanTick) hold_ticks++;
         if (returned && !Busy && ScanTick) post_ticks++;
      end
      IrqReq = 1'b0;
      vectors++;
      if (!second || acks != 2 || acks_in_hold != 0) begin
         miscompares++;
         $display("FAIL held_acks: total %0d, during hold %0d, second seen %0d, want 2, 0, 1",
                  acks, acks_in_hold, second);
      end
      exp_q.delete();
      // Let the second message run out so the next scenario starts from the CPU view.
      for (int c = 0; c < 60 && (Busy || Owner || c < 2); c++) step();
   endtask

   task automatic test_reset_mid_hold();
      bit got_ack = 0;
      int first   = -1;
      wait_eligible("rst_hold");
      IrqReq  = 1'b1;
      IrqCode = 24'h777777;
      for (int c = 0; c < 10 && !got_ack; c++) begin
         step();
         if (IrqAck) got_ack = 1;
      end
      IrqReq = 1'b0;
      repeat (6) step();
      vectors++;
      if (!got_ack || Busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_hold_setup: ack=%0d busy=%b, want ack=1 busy=1", got_ack, Busy);
      end
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      vectors++;
      if ({Data, DisplayEnables, Owner, Busy, IrqAck, ScanTick} !== 33'h0) begin
         miscompares++;
         $display("FAIL rst_hold_outputs: got data=%h en=%b own=%b busy=%b ack=%b tick=%b, want all 0",
                  Data, DisplayEnables, Owner, Busy, IrqAck, ScanTick);
      end
      for (int n = 1; n <= 6; n++) begin
         step();
         if (ScanTick && first < 0) first = n;
         if (IrqAck || Owner || Data !== 24'h0) begin
            vectors++;
            miscompares++;
            $display("FAIL rst_hold_after: step %0d ack=%b own=%b data=%h, want 0 0 000000",
                     n, IrqAck, Owner, Data);
         end
      end
      vectors++;
      if (first != 3) begin
         miscompares++;
         $display("FAIL rst_hold_tick: first ScanTick at step %0d, want step 3", first);
      end
   endtask

   initial begin
      test_reset();
      test_cpu_write();
      test_irq_hold();
      test_simultaneous();
      test_held_request();
      test_reset_mid_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
